// File: rtl/clk_period_mon.sv
// clk_period_mon: measures an asynchronous monitored clock's period in clk_i cycles and flags too-fast/too-slow clocks; define CLK_PERIOD_MON_DUTY_EN to also report high time
module clk_period_mon #(
    parameter int CNT_WIDTH   = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 en_i,
    input  logic                 clr_i,
    input  logic                 mon_clk_i,
    input  logic [CNT_WIDTH-1:0] min_period_i,
    input  logic [CNT_WIDTH-1:0] max_period_i,
    output logic [CNT_WIDTH-1:0] period_o,
    output logic [CNT_WIDTH-1:0] high_o,
    output logic                 valid_o,
    output logic                 too_fast_o,
    output logic                 too_slow_o
);
    typedef enum logic [1:0] {IDLE, ARM, MEAS} state_t;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
    state_t                 r_state, w_state_next;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic                   w_sync, w_rise;
    logic [CNT_WIDTH-1:0]   r_cnt, w_cnt_next, w_cnt_inc;
    logic [CNT_WIDTH-1:0]   r_period;
    logic                   r_valid, r_too_fast, r_too_slow;
    logic                   w_publish, w_fast_set, w_slow_set;

    assign w_sync    = r_sync[SYNC_STAGES-1];
    assign w_rise    = w_sync & ~r_prev;
    assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_ONE;

    // bring the monitored clock into clk_i domain and keep last synced level for edge detection
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], mon_clk_i};
            r_prev <= w_sync;
        end
    end

    // next state, counter update and flag set conditions; disable always wins
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = '0;
        w_publish    = 1'b0;
        w_fast_set   = 1'b0;
        w_slow_set   = 1'b0;
        if (!en_i) begin
            w_state_next = IDLE;
        end else begin
            case (r_state)
                IDLE: w_state_next = ARM;
                ARM: begin
                    w_state_next = w_rise ? MEAS : ARM;
                    w_cnt_next   = w_rise ? CNT_ONE : '0;
                end
                MEAS: begin
                    w_publish  = w_rise;
                    w_fast_set = w_rise & (r_cnt < min_period_i);
                    w_slow_set = ~w_rise & (w_cnt_inc > max_period_i);
                    w_cnt_next = w_rise ? CNT_ONE : w_cnt_inc;
                end
                default: w_state_next = IDLE;
            endcase
        end
    end

    // state, period counter, published period and sticky flags (set beats clear)
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_period   <= '0;
            r_valid    <= 1'b0;
            r_too_fast <= 1'b0;
            r_too_slow <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_cnt      <= w_cnt_next;
            r_valid    <= w_publish;
            r_too_fast <= w_fast_set | (r_too_fast & ~clr_i);
            r_too_slow <= w_slow_set | (r_too_slow & ~clr_i);
            if (w_publish) r_period <= r_cnt;
        end
    end

`ifdef CLK_PERIOD_MON_DUTY_EN
    logic                 w_fall;
    logic [CNT_WIDTH-1:0] r_hcnt, r_hcap, r_high, w_hcnt_inc;

    assign w_fall     = ~w_sync & r_prev;
    assign w_hcnt_inc = (r_hcnt == CNT_MAX) ? r_hcnt : r_hcnt + CNT_ONE;

    // count synced-high cycles from each rise, capture on fall, publish alongside the period
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_hcnt <= '0;
            r_hcap <= '0;
            r_high <= '0;
        end else begin
            if (!en_i) r_hcnt <= '0;
            else if (r_state == MEAS) r_hcnt <= w_rise ? CNT_ONE : (w_sync ? w_hcnt_inc : r_hcnt);
            else r_hcnt <= (r_state == ARM && w_rise) ? CNT_ONE : '0;
            if (en_i && r_state == MEAS && w_fall) r_hcap <= r_hcnt;
            if (w_publish) r_high <= r_hcap;
        end
    end

    assign high_o = r_high;
`else
    assign high_o = '0;
`endif

    assign period_o   = r_period;
    assign valid_o    = r_valid;
    assign too_fast_o = r_too_fast;
    assign too_slow_o = r_too_slow;
endmodule

// File: tb/tb_clk_period_mon.sv
// tb_clk_period_mon: directed stimulus with an edge-history reference model checked every cycle
module tb_clk_period_mon;
    localparam int D = 2;
`ifdef CLK_PERIOD_MON_DUTY_EN
    localparam bit DUTY = 1'b1;
`else
    localparam bit DUTY = 1'b0;
`endif
    logic        clk = 1'b0, rst = 1'b1, en = 1'b0, clr = 1'b0, mon = 1'b0;
    logic [15:0] min16 = 16'd0, max16 = 16'd100;
    logic [3:0]  min4 = 4'd0, max4 = 4'd15;
    logic [15:0] p16, h16;
    logic [3:0]  p4, h4;
    logic        v16, v4, tf16, tf4, ts16, ts4;
    int          vectors = 0, miscompares = 0;

    always #5 clk = ~clk;

    clk_period_mon #(.CNT_WIDTH(16), .SYNC_STAGES(D)) u16 (
        .clk_i(clk), .rst_i(rst), .en_i(en), .clr_i(clr), .mon_clk_i(mon),
        .min_period_i(min16), .max_period_i(max16), .period_o(p16), .high_o(h16),
        .valid_o(v16), .too_fast_o(tf16), .too_slow_o(ts16));

    clk_period_mon #(.CNT_WIDTH(4), .SYNC_STAGES(D)) u4 (
        .clk_i(clk), .rst_i(rst), .en_i(en), .clr_i(clr), .mon_clk_i(mon),
        .min_period_i(min4), .max_period_i(max4), .period_o(p4), .high_o(h4),
        .valid_o(v4), .too_fast_o(tf4), .too_slow_o(ts4));

    function automatic int o_v(int n);   return n == 0 ? int'(v16)  : int'(v4);  endfunction
    function automatic int o_per(int n); return n == 0 ? int'(p16)  : int'(p4);  endfunction
    function automatic int o_hi(int n);  return n == 0 ? int'(h16)  : int'(h4);  endfunction
    function automatic int o_tf(int n);  return n == 0 ? int'(tf16) : int'(tf4); endfunction
    function automatic int o_ts(int n);  return n == 0 ? int'(ts16) : int'(ts4); endfunction
    function automatic int sat(int n);   return n == 0 ? 65535 : 15;             endfunction

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // monitored clock source: new period/high settings take effect at a rising edge
    int mon_per = 8, mon_hi = 4, cur_per = 8, cur_hi = 4, ph = 0;
    bit mon_run = 1'b0, mon_hold = 1'b0;
    initial forever begin
        @(posedge clk);
        #2;
        if (!mon_run) begin
            mon = mon_hold;
            ph  = 0;
        end else begin
            if (ph == 0) begin
                cur_per = mon_per;
                cur_hi  = mon_hi;
            end
            mon = (ph < cur_hi);
            ph  = (ph + 1 >= cur_per) ? 0 : ph + 1;
        end
    end

    // record what every clk edge sampled
    int k = 0, kr = -1;
    bit mon_h [0:8191];
    bit c_rst, c_en, c_clr;
    int c_min [2], c_max [2];
    initial forever begin
        @(posedge clk);
        k++;
        if (k > 8190) begin
            $display("FAIL history overflow: got %0d cycles, expected under 8190", k);
            $fatal(1);
        end
        mon_h[k] = mon;
        c_rst = rst; c_en = en; c_clr = clr;
        c_min[0] = int'(min16); c_max[0] = int'(max16);
        c_min[1] = int'(min4);  c_max[1] = int'(max4);
    end

    // synced view of the monitored clock: anything sampled at or before the last reset reads as 0
    function automatic bit val(int i);
        return (i < 1 || i <= kr) ? 1'b0 : mon_h[i];
    endfunction

    // reference model: periods are distances between detected rising edges, in clk edges
    int m_ph [2], m_r [2], m_cap [2], e_per [2], e_high [2];
    bit e_v [2], e_tf [2], e_ts [2];
    bit rise, fall, fs, ss;
    int c;
    initial begin
        for (int n = 0; n < 2; n++) begin
            m_ph[n] = 0; m_r[n] = 0; m_cap[n] = 0; e_per[n] = 0; e_high[n] = 0;
            e_v[n] = 0; e_tf[n] = 0; e_ts[n] = 0;
        end
        forever begin
            @(negedge clk);
            if (k > 0) begin
                if (c_rst) kr = k;
                rise = val(k - D) && !val(k - D - 1);
                fall = !val(k - D) && val(k - D - 1);
                for (int n = 0; n < 2; n++) begin
                    fs = 1'b0;
                    ss = 1'b0;
                    e_v[n] = 1'b0;
                    if (c_rst) begin
                        m_ph[n] = 0; m_cap[n] = 0; e_per[n] = 0; e_high[n] = 0;
                        e_tf[n] = 0; e_ts[n] = 0;
                    end else begin
                        if (!c_en) m_ph[n] = 0;
                        else if (m_ph[n] == 0) m_ph[n] = 1;
                        else if (m_ph[n] == 1) begin
                            if (rise) begin m_ph[n] = 2; m_r[n] = k; end
                        end else if (rise) begin
                            c = k - m_r[n];
                            if (c > sat(n)) c = sat(n);
                            e_v[n] = 1'b1;
                            e_per[n] = c;
                            e_high[n] = DUTY ? m_cap[n] : 0;
                            fs = (c < c_min[n]);
                            m_r[n] = k;
                        end else begin
                            c = k - m_r[n] + 1;
                            if (c > sat(n)) c = sat(n);
                            ss = (c > c_max[n]);
                            if (fall) begin
                                c = k - m_r[n];
                                m_cap[n] = (c > sat(n)) ? sat(n) : c;
                            end
                        end
                        e_tf[n] = fs || (e_tf[n] && !c_clr);
                        e_ts[n] = ss || (e_ts[n] && !c_clr);
                    end
                    check($sformatf("w%0d valid cyc%0d", n, k), o_v(n), int'(e_v[n]));
                    check($sformatf("w%0d period cyc%0d", n, k), o_per(n), e_per[n]);
                    check($sformatf("w%0d high cyc%0d", n, k), o_hi(n), e_high[n]);
                    check($sformatf("w%0d too_fast cyc%0d", n, k), o_tf(n), int'(e_tf[n]));
                    check($sformatf("w%0d too_slow cyc%0d", n, k), o_ts(n), int'(e_ts[n]));
                end
            end
        end
    end

    task automatic wait_valid(input int n, input int budget);
        bit got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk);
            got = o_v(n) != 0;
        end
        check($sformatf("wait valid w%0d", n), int'(got), 1);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset period", int'(p16), 0);
        check("reset valid", int'(v16), 0);
        check("reset too_fast", int'(tf16), 0);
        check("reset too_slow", int'(ts16), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        // 8-cycle 50% clock
        @(posedge clk); #1;
        min16 = 16'd4; max16 = 16'd20; en = 1'b1; mon_per = 8; mon_hi = 4; mon_run = 1'b1;
        wait_valid(0, 60);
        check("t1 period", int'(p16), 8);
        check("t1 high", int'(h16), DUTY ? 4 : 0);
        check("t1 too_fast", int'(tf16), 0);
        check("t1 too_slow", int'(ts16), 0);
        wait_valid(0, 20);
        check("t1 period again", int'(p16), 8);
        // period 6 below min 10, clr coinciding with a set keeps the flag
        @(posedge clk); #1;
        min16 = 16'd10; mon_per = 6; mon_hi = 3;
        repeat (3) wait_valid(0, 20);
        check("t2 period", int'(p16), 6);
        check("t2 too_fast", int'(tf16), 1);
        repeat (5) @(posedge clk);
        #1 clr = 1'b1;
        @(posedge clk);
        #1 clr = 1'b0;
        @(negedge clk);
        check("t2 valid with clr", int'(v16), 1);
        check("t2 set beats clr", int'(tf16), 1);
        @(posedge clk);
        #1 clr = 1'b1;
        @(posedge clk);
        #1 clr = 1'b0;
        @(negedge clk);
        check("t2 clr alone", int'(tf16), 0);
        // clock stops high, then restarts
        @(posedge clk); #1;
        min16 = 16'd4; mon_per = 8; mon_hi = 4;
        repeat (3) wait_valid(0, 20);
        mon_hold = 1'b1; mon_run = 1'b0;
        repeat (19) @(negedge clk);
        check("t3 too_slow before cnt 21", int'(ts16), 0);
        @(negedge clk);
        check("t3 too_slow at cnt 21", int'(ts16), 1);
        repeat (20) @(negedge clk);
        mon_run = 1'b1;
        wait_valid(0, 30);
        check("t3 long gap", int'(p16), 52);
        check("t3 w4 saturated", int'(p4), 15);
        check("t3 too_slow sticky", int'(ts16), 1);
        wait_valid(0, 20);
        check("t3 period after restart", int'(p16), 8);
        // enable dropped mid-period
        wait_valid(0, 20);
        repeat (3) @(posedge clk);
        #1 en = 1'b0;
        repeat (6) @(posedge clk);
        #1 en = 1'b1;
        wait_valid(0, 40);
        check("t4 period after re-enable", int'(p16), 8);
        // 4-bit counter saturation with period 40
        @(posedge clk); #1;
        clr = 1'b1; max16 = 16'd100; max4 = 4'd12; mon_per = 40; mon_hi = 20;
        @(posedge clk); #1;
        clr = 1'b0;
        repeat (4) wait_valid(1, 60);
        check("t5 w4 period", int'(p4), 15);
        check("t5 w4 too_slow", int'(ts4), 1);
        check("t5 w16 period", int'(p16), 40);
        check("t5 w16 too_slow", int'(ts16), 0);
        // 3/10 duty, reset mid-measurement
        @(posedge clk); #1;
        clr = 1'b1; max16 = 16'd20; max4 = 4'd15; mon_per = 10; mon_hi = 3;
        @(posedge clk); #1;
        clr = 1'b0;
        repeat (3) wait_valid(0, 60);
        check("t6 period", int'(p16), 10);
        check("t6 high", int'(h16), DUTY ? 3 : 0);
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("t6 reset period", int'(p16), 0);
        check("t6 reset high", int'(h16), 0);
        check("t6 reset too_slow", int'(ts4), 0);
        wait_valid(0, 40);
        check("t6 period after reset", int'(p16), 10);
        check("t6 high after reset", int'(h16), DUTY ? 3 : 0);
        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
